// File: rtl/bus_pkg.sv
// Shared encodings and command record for the register-to-register bus sequencer.
package bus_pkg;

    localparam logic [1:0] PART_L   = 2'b00;
    localparam logic [1:0] PART_H   = 2'b01;
    localparam logic [1:0] PART_W   = 2'b10;
    localparam logic [1:0] PART_BAD = 2'b11;

    // Index fields are carried at a fixed maximum width so the struct is not parameterized.
    localparam int IDX_W_MAX = 8;

    typedef struct packed {
        logic                 id;
        logic [IDX_W_MAX-1:0] src;
        logic [IDX_W_MAX-1:0] dst;
        logic [1:0]           spart;
        logic [1:0]           dpart;
    } xfer_cmd_t;

    // 8-bit parts mix freely; the 16-bit part only pairs with itself.
    function automatic logic parts_legal(input logic [1:0] sp, input logic [1:0] dp);
        return (sp != PART_BAD) && (dp != PART_BAD) && ((sp == PART_W) == (dp == PART_W));
    endfunction

endpackage

// File: rtl/xfer_rr_arbiter.sv
// Two-way round-robin arbiter with an eligibility mask; pointer flips away from each winner.
module xfer_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       id,
    output logic       any
);

    logic rr;

    always_ff @(posedge clk) begin
        if (rst)
            rr <= 1'b0;
        else if (accept)
            rr <= ~id;
    end

    always_comb begin
        any   = |elig;
        id    = (elig == 2'b11) ? rr : elig[1];
        grant = 2'b00;
        if (any)
            grant = id ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Two-stage (read, write) sequencer for register moves over the shared 16-bit internal bus.
module bus_xfer_sequencer
    import bus_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*IW-1:0]   req_src,
    input  logic [2*IW-1:0]   req_dst,
    input  logic [3:0]        req_spart,
    input  logic [3:0]        req_dpart,
    output logic [NREGS-1:0]  cs_h_out,
    output logic [NREGS-1:0]  cs_l_out,
    output logic [NREGS-1:0]  cs_16_out,
    output logic [NREGS-1:0]  cs_h_in,
    output logic [NREGS-1:0]  cs_l_in,
    output logic [NREGS-1:0]  cs_16_in,
    output logic              done,
    output logic              done_id,
    output logic              err,
    output logic              err_id
);

    xfer_cmd_t            cmd_in [2];
    xfer_cmd_t            sel_cmd;
    xfer_cmd_t            a_cmd;
    logic                 a_vld;
    logic                 b_vld;
    logic                 b_id;
    logic [IDX_W_MAX-1:0] b_dst;
    logic [1:0]           b_dpart;
    logic [1:0]           elig;
    logic [1:0]           grant;
    logic                 gid;
    logic                 gany;
    logic                 accept;
    logic                 sel_legal;
    logic [NREGS-1:0]     a_sel;
    logic [NREGS-1:0]     b_sel;

    // A requester reading the register currently being moved into must wait a cycle.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            cmd_in[r]       = '0;
            cmd_in[r].id    = 1'(r);
            cmd_in[r].src   = IDX_W_MAX'(req_src[r*IW +: IW]);
            cmd_in[r].dst   = IDX_W_MAX'(req_dst[r*IW +: IW]);
            cmd_in[r].spart = req_spart[2*r +: 2];
            cmd_in[r].dpart = req_dpart[2*r +: 2];
            elig[r] = req_valid[r] & ~(a_vld & (cmd_in[r].src == a_cmd.dst));
        end
    end

    xfer_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .elig   (elig),
        .accept (accept),
        .grant  (grant),
        .id     (gid),
        .any    (gany)
    );

    assign accept    = gany & ~rst;
    assign req_ready = grant & {2{~rst}};
    assign sel_cmd   = cmd_in[gid];
    assign sel_legal = parts_legal(sel_cmd.spart, sel_cmd.dpart)
                     && (sel_cmd.src < IDX_W_MAX'(NREGS))
                     && (sel_cmd.dst < IDX_W_MAX'(NREGS));

    // Write stage keeps only the fields it needs to drive the destination strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld   <= 1'b0;
            a_cmd   <= '0;
            b_vld   <= 1'b0;
            b_id    <= 1'b0;
            b_dst   <= '0;
            b_dpart <= PART_L;
            err     <= 1'b0;
            err_id  <= 1'b0;
        end else begin
            b_vld   <= a_vld;
            b_id    <= a_cmd.id;
            b_dst   <= a_cmd.dst;
            b_dpart <= a_cmd.dpart;
            a_vld   <= accept & sel_legal;
            if (accept & sel_legal)
                a_cmd <= sel_cmd;
            err     <= accept & ~sel_legal;
            err_id  <= accept & ~sel_legal & gid;
        end
    end

    assign a_sel = NREGS'(1) << a_cmd.src;
    assign b_sel = NREGS'(1) << b_dst;

    always_comb begin
        cs_h_out  = '0;
        cs_l_out  = '0;
        cs_16_out = '0;
        cs_h_in   = '0;
        cs_l_in   = '0;
        cs_16_in  = '0;
        if (a_vld) begin
            case (a_cmd.spart)
                PART_L:  cs_l_out  = a_sel;
                PART_H:  cs_h_out  = a_sel;
                PART_W:  cs_16_out = a_sel;
                default: ;
            endcase
        end
        if (b_vld) begin
            case (b_dpart)
                PART_L:  cs_l_in  = b_sel;
                PART_H:  cs_h_in  = b_sel;
                PART_W:  cs_16_in = b_sel;
                default: ;
            endcase
        end
    end

    assign done    = b_vld;
    assign done_id = b_vld & b_id;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: register-file bus model, strobe/ready scoreboard, vector table.
module tb_bus_xfer_sequencer;
    import bus_pkg::*;

    localparam int NREGS = 4;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [2*IW-1:0]   req_src = '0;
    logic [2*IW-1:0]   req_dst = '0;
    logic [3:0]        req_spart = '0;
    logic [3:0]        req_dpart = '0;
    logic [NREGS-1:0]  cs_h_out, cs_l_out, cs_16_out, cs_h_in, cs_l_in, cs_16_in;
    logic              done, done_id, err, err_id;

    always #5 clk = ~clk;

    bus_xfer_sequencer #(.NREGS(NREGS), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_spart(req_spart), .req_dpart(req_dpart),
        .cs_h_out(cs_h_out), .cs_l_out(cs_l_out), .cs_16_out(cs_16_out),
        .cs_h_in(cs_h_in), .cs_l_in(cs_l_in), .cs_16_in(cs_16_in),
        .done(done), .done_id(done_id), .err(err), .err_id(err_id)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Register file on the bus: reads drive the bus for one cycle, writes take the held bus.
    logic [15:0] pat [NREGS] = '{16'h3C11, 16'h5A22, 16'h7E33, 16'h9F44};
    logic [15:0] regs [NREGS];
    logic [15:0] bus_q;
    logic [15:0] rd_now;
    logic        ld = 1'b1;

    always_comb begin
        rd_now = 16'h0;
        for (int i = 0; i < NREGS; i++) begin
            if (cs_l_out[i])  rd_now = {8'h00, regs[i][7:0]};
            if (cs_h_out[i])  rd_now = {8'h00, regs[i][15:8]};
            if (cs_16_out[i]) rd_now = regs[i];
        end
    end

    always @(posedge clk) begin
        bus_q <= rd_now;
        for (int i = 0; i < NREGS; i++) begin
            if (ld) regs[i] <= pat[i];
            else begin
                if (cs_l_in[i])  regs[i][7:0]  <= bus_q[7:0];
                if (cs_h_in[i])  regs[i][15:8] <= bus_q[7:0];
                if (cs_16_in[i]) regs[i]       <= bus_q;
            end
        end
    end

    function automatic logic [63:0] regs_flat();
        return {regs[3], regs[2], regs[1], regs[0]};
    endfunction

    function automatic logic legal(input logic [1:0] sp, input logic [1:0] dp);
        return sp != 2'b11 && dp != 2'b11 && ((sp == 2'b10) == (dp == 2'b10));
    endfunction

    function automatic logic [63:0] after_move(input int s, input int d, input logic [1:0] sp,
                                               input logic [1:0] dp, input logic ok);
        logic [15:0] r [NREGS];
        logic [15:0] v;
        for (int i = 0; i < NREGS; i++) r[i] = pat[i];
        if (ok) begin
            v = (sp == PART_W) ? r[s] : (sp == PART_H) ? {8'h00, r[s][15:8]} : {8'h00, r[s][7:0]};
            case (dp)
                PART_W:  r[d] = v;
                PART_H:  r[d][15:8] = v[7:0];
                default: r[d][7:0] = v[7:0];
            endcase
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    // Scoreboard: each accepted legal command is expected as a read one cycle later, a write two.
    typedef struct { logic id; int src; int dst; logic [1:0] sp; logic [1:0] dp; int due; } exp_t;
    exp_t rd_q[$];
    exp_t wr_q[$];
    int   cyc = 0;
    logic rr_m = 1'b0;
    logic err_e = 1'b0, err_id_e = 1'b0;

    always @(negedge clk) begin : mon
        logic [NREGS-1:0] eho, elo, e16o, ehi, eli, e16i;
        logic ed, edi, a_v;
        int a_dst;
        logic [1:0] el, er;
        exp_t e;
        cyc++;
        eho = '0; elo = '0; e16o = '0; ehi = '0; eli = '0; e16i = '0;
        ed = 1'b0; edi = 1'b0; a_v = 1'b0; a_dst = 0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            a_v = 1'b1; a_dst = e.dst;
            case (e.sp)
                PART_L:  elo[e.src]  = 1'b1;
                PART_H:  eho[e.src]  = 1'b1;
                default: e16o[e.src] = 1'b1;
            endcase
        end
        if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
            e = wr_q.pop_front();
            ed = 1'b1; edi = e.id;
            case (e.dp)
                PART_L:  eli[e.dst]  = 1'b1;
                PART_H:  ehi[e.dst]  = 1'b1;
                default: e16i[e.dst] = 1'b1;
            endcase
        end
        chk("strobes_done",
            {cs_h_out, cs_l_out, cs_16_out, cs_h_in, cs_l_in, cs_16_in, done, done_id},
            {eho, elo, e16o, ehi, eli, e16i, ed, edi});
        chk("err", {err, err_id}, {err_e, err_id_e});
        for (int r = 0; r < 2; r++)
            el[r] = req_valid[r] && !(a_v && int'(req_src[r*IW +: IW]) == a_dst);
        er = 2'b00;
        if (!rst) begin
            if (el == 2'b11) er[rr_m] = 1'b1;
            else             er = el;
        end
        chk("ready", req_ready, er);
        err_e = 1'b0; err_id_e = 1'b0;
        if (rst) begin
            rd_q.delete(); wr_q.delete(); rr_m = 1'b0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    rr_m = (r == 0);
                    e.id = 1'(r);
                    e.src = int'(req_src[r*IW +: IW]);
                    e.dst = int'(req_dst[r*IW +: IW]);
                    e.sp = req_spart[2*r +: 2];
                    e.dp = req_dpart[2*r +: 2];
                    if (legal(e.sp, e.dp)) begin
                        e.due = cyc + 1; rd_q.push_back(e);
                        e.due = cyc + 2; wr_q.push_back(e);
                    end else begin
                        err_e = 1'b1; err_id_e = 1'(r);
                    end
                end
            end
        end
    end

    task automatic set_req(input int r, input logic v, input int s, input int d,
                           input logic [1:0] sp, input logic [1:0] dp);
        req_valid[r]        = v;
        req_src[r*IW +: IW] = s[IW-1:0];
        req_dst[r*IW +: IW] = d[IW-1:0];
        req_spart[2*r +: 2] = sp;
        req_dpart[2*r +: 2] = dp;
    endtask

    // Called just after a rising edge; returns just after the accepting edge with valid dropped.
    task automatic issue(input int r, input int s, input int d, input logic [1:0] sp, input logic [1:0] dp);
        logic ok;
        ok = 1'b0;
        set_req(r, 1'b1, s, d, sp, dp);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        if (!ok) begin
            nvec++; nmis++;
            $display("FAIL issue_timeout: requester %0d never accepted", r);
        end
    endtask

    task automatic load_regs();
        ld = 1'b1; @(posedge clk); #1; ld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    endtask

    typedef struct { int id; int s; int d; logic [1:0] sp; logic [1:0] dp; logic exp_err; } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{0, 1, 2, PART_H,   PART_L, 1'b0};
        tbl[1] = '{1, 0, 3, PART_W,   PART_W, 1'b0};
        tbl[2] = '{0, 2, 2, PART_L,   PART_H, 1'b0};
        tbl[3] = '{1, 3, 0, PART_H,   PART_H, 1'b0};
        tbl[4] = '{1, 0, 1, PART_W,   PART_H, 1'b1};
        tbl[5] = '{0, 1, 2, PART_L,   PART_W, 1'b1};
        tbl[6] = '{0, 0, 1, PART_BAD, PART_L, 1'b1};
        tbl[7] = '{1, 1, 1, PART_W,   PART_W, 1'b0};

        repeat (2) @(posedge clk);
        #1; rst = 1'b0; ld = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {cs_h_out, cs_l_out, cs_16_out, cs_h_in, cs_l_in, cs_16_in, done, done_id, err, err_id}, '0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            load_regs();
            issue(tbl[i].id, tbl[i].s, tbl[i].d, tbl[i].sp, tbl[i].dp);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regs", i), regs_flat(),
                after_move(tbl[i].s, tbl[i].d, tbl[i].sp, tbl[i].dp, !tbl[i].exp_err));
        end

        // Back-to-back W moves with no bubble.
        load_regs();
        set_req(0, 1'b1, 0, 1, PART_W, PART_W);
        @(negedge clk); chk("b2b_acc0", req_ready, 2'b01);
        @(posedge clk); #1; set_req(0, 1'b1, 2, 3, PART_W, PART_W);
        @(negedge clk); chk("b2b_acc1", req_ready, 2'b01);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk); chk("b2b_done0", done, 1'b1);
        @(negedge clk); chk("b2b_done1", done, 1'b1);
        repeat (3) @(posedge clk);
        #1; chk("b2b_regs", regs_flat(), {pat[2], pat[2], pat[0], pat[0]});

        // Read-after-write hazard stalls one cycle and reads the fresh value.
        load_regs();
        set_req(0, 1'b1, 0, 1, PART_L, PART_L);
        @(negedge clk); chk("raw_acc0", req_ready, 2'b01);
        @(posedge clk); #1; set_req(0, 1'b1, 1, 2, PART_L, PART_L);
        @(negedge clk); chk("raw_stall", req_ready, 2'b00);
        @(posedge clk); #1;
        @(negedge clk); chk("raw_acc1", req_ready, 2'b01);
        @(posedge clk); #1; req_valid = '0;
        repeat (4) @(posedge clk);
        #1; chk("raw_regs", regs_flat(),
                {pat[3], pat[2][15:8], pat[0][7:0], pat[1][15:8], pat[0][7:0], pat[0]});

        // Round-robin alternation after reset.
        do_reset();
        set_req(0, 1'b1, 0, 1, PART_L, PART_L);
        set_req(1, 1'b1, 2, 3, PART_H, PART_H);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); chk($sformatf("arb_alt%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Hazard-blocked requester loses, pointer still moves past the winner.
        do_reset();
        set_req(1, 1'b1, 3, 1, PART_L, PART_L);
        @(negedge clk); chk("hz_g0", req_ready, 2'b10);
        @(posedge clk); #1;
        set_req(0, 1'b1, 0, 2, PART_L, PART_L);
        set_req(1, 1'b1, 1, 3, PART_H, PART_H);
        @(negedge clk); chk("hz_g1", req_ready, 2'b01);
        @(posedge clk); #1; set_req(0, 1'b1, 0, 0, PART_H, PART_L);
        @(negedge clk); chk("hz_g2", req_ready, 2'b10);
        @(posedge clk); #1; req_valid[1] = 1'b0;
        @(negedge clk); chk("hz_g3", req_ready, 2'b01);
        @(posedge clk); #1; req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset on the edge that ends the read cycle abandons the transfer.
        load_regs();
        issue(0, 1, 2, PART_W, PART_W);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out", {cs_h_out, cs_l_out, cs_16_out, cs_h_in, cs_l_in, cs_16_in, done, done_id, err, err_id}, '0);
        repeat (3) @(posedge clk);
        #1; chk("rst_mid_regs", regs_flat(), {pat[3], pat[2], pat[1], pat[0]});
        set_req(0, 1'b1, 0, 1, PART_L, PART_L);
        set_req(1, 1'b1, 2, 3, PART_L, PART_L);
        @(negedge clk); chk("rst_rr", req_ready, 2'b01);
        @(posedge clk); #1; req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(rd_q.size() + wr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
- Schedules register-to-register moves over the shared 16-bit internal bus between NREGS DoubleRegister8 instances.
- Arbitrates between two requesters (0 = instruction decoder, 1 = interrupt/service unit).
- Drives the per-register cs_*_out / cs_*_in strobes as a 2-stage pipeline: read stage, then write stage.
- Sustains one transfer per cycle and stalls on read-after-write hazards.

Parameters:
- NREGS, 4, number of register pairs on the bus (power of two, >=2).
- IW, $clog2(NREGS), register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- req_valid  in  2  per-requester command valid.
- req_ready  out  2  per-requester accept (combinational); accept = valid & ready.
- req_src  in  2*IW  per-requester source register index ([IW-1:0] = requester 0).
- req_dst  in  2*IW  per-requester destination register index.
- req_spart  in  4  per-requester source part, 2 bits each: 00 = L, 01 = H, 10 = W(16-bit), 11 = illegal.
- req_dpart  in  4  per-requester destination part, same encoding.
- cs_h_out, cs_l_out, cs_16_out  out  NREGS each  one-hot read strobes to the registers.
- cs_h_in, cs_l_in, cs_16_in  out  NREGS each  one-hot write strobes to the registers.
- done  out  1  high during the write cycle of a transfer.
- done_id  out  1  requester that owns the transfer in the write cycle.
- err  out  1  one-cycle pulse: an illegal command was accepted and dropped.
- err_id  out  1  requester of the dropped command.

Behaviour:
- Pipeline registers: A (read) and B (write), each holding {valid, id, src, dst, spart, dpart}.
- Cycle with A.valid: exactly one read strobe is high, at bit A.src (L→cs_l_out, H→cs_h_out, W→cs_16_out).
- Cycle with B.valid: exactly one write strobe is high, at bit B.dst. In the same cycle done=1 and done_id=B.id.
- All strobes are 0 when the stage is empty.
- Every edge: B <= A. A <= accepted legal command, else A.valid <= 0. Stage A never stalls.
- Latency: accept at edge E0 → source strobe in cycle after E0 → bus valid after E1 → destination captures at E2.
- 8-bit parts may be mixed freely (L→H, H→L, same register allowed), because 8-bit reads land on bus[7:0] and 8-bit writes take bus[7:0].
- Legality: W only pairs with W. Part 11 is illegal. An index >= NREGS is illegal.
- An illegal command is still accepted (ready=1 if granted), never enters A, and raises err/err_id in the next cycle.
- Hazard: requester r is ineligible when A.valid and req_src[r] == A.dst (any parts, conservative). It waits; ready[r]=0.
- Arbitration: round-robin among eligible valid requesters. Pointer rr starts at 0.
  - Both eligible → grant rr.
  - One eligible → grant it.
  - After any accept, rr <= ~granted_id.
- At most one ready bit high per cycle.
- Requesters must hold valid and fields stable until accepted.
- Reset: A/B invalid, rr=0. All strobes, done, done_id, err, err_id are 0 in the cycle after the reset edge.
- Reset mid-transfer abandons it: a destination whose write edge coincides with reset is not written.
- Simultaneous reset and valid: no accept.

Decomposition:
- Shared package bus_pkg: part encodings (PART_L, PART_H, PART_W, PART_BAD) and a xfer_cmd_t struct {id, src, dst, spart, dpart}.
- Natural sub-module: xfer_rr_arbiter (2-way round-robin with eligibility mask, outputs grant + id).
- Strobe decode is inline.

Test Plan:
- Single move: NREGS=4, r1.H=0x5A, req0 {src1 H → dst2 L}. Accept E0 → cs_h_out[1] in cycle 1, cs_l_in[2] + done, done_id=0 in cycle 2; r2.L=0x5A after E2.
- Back-to-back: req0 {0 W → 1 W} then {2 W → 3 W} on consecutive cycles. Both accepted without a bubble; done high two consecutive cycles; r1=r0, r3=r2.
- RAW stall: {0 L → 1 L} accepted, then {1 L → 2 L} next cycle. ready=0 for one cycle, then accepted; r2.L equals the original r0.L, not the stale r1.L.
- Arbitration: both requesters valid continuously with non-conflicting moves. Grants alternate 0,1,0,1; after reset the first grant is 0. Req1 ineligible by hazard → req0 granted, rr still flips.
- Illegal command: req1 {src0 W → dst1 H}. Accepted; err=1, err_id=1 the next cycle; no strobe asserted; register contents unchanged.
- Reset mid-operation: assert rst on the edge ending the read cycle. No write strobe follows; destination unchanged; all outputs 0; rr=0.
